// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encodings, opcodes, ALU selects.
// MC_BNE_EN (see multicycle_ctrl) only changes how OP_BNE decodes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_ADDI_EX  = 4'd8,
        S_ADDI_WB  = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12,
        S_HALT     = 4'd13
    } mc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // States in which the controller stalls on mem_ready
    function automatic logic is_mem_wait(input mc_state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive stalled cycles in a memory-wait state; expired fires on the
// TIMEOUT_CYCLES-th stalled cycle so the controller can bail out that same cycle.
module mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    assign expired = waiting && (r_count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (waiting && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with memory-timeout watchdog.
// Define MC_BNE_EN to decode opcode 000101 as bne; otherwise it traps as illegal.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       bne,
    output logic       jump,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       fault,
    output logic [3:0] state
);

`ifdef MC_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    mc_state_e r_state;
    mc_state_e w_next;
    logic      r_fault;
    logic      w_waiting;
    logic      w_expired;
    logic      w_clear;
    logic      w_bne;

    assign w_waiting = is_mem_wait(r_state) && !mem_ready;
    // Any state change counts as a fresh entry, so the count always starts at zero
    assign w_clear   = mem_ready || (w_next != r_state);
    assign w_bne     = BNE_EN && (opcode == OP_BNE);

    mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_clear),
        .waiting(w_waiting),
        .expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_expired) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign fault = r_fault;
    assign state = r_state;

    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        bne        = 1'b0;
        jump       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_RTYPE:     w_next = S_EXEC_R;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_ADDI:      w_next = S_ADDI_EX;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_BNE:       w_next = BNE_EN ? S_BRANCH : S_ILLEGAL;
                    default:      w_next = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                branch    = 1'b1;
                bne       = w_bne;
                pc_write  = zero ^ w_bne;
                w_next    = S_FETCH;
            end
            S_JUMP: begin
                jump     = 1'b1;
                pc_write = 1'b1;
                w_next   = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                w_next  = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Timeout abandons the stalled access: drop the request before heading to HALT
        if (w_expired) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            iord    = 1'b0;
            w_next  = S_HALT;
        end
    end

endmodule
